// File: rtl/ball_pkg.sv
// ball_pkg: shared state encoding and playfield constants for the ball game path
package ball_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_FREEZE = 2'd2,
        ST_OVER   = 2'd3
    } state_t;
    localparam int Y_MIN     = 84;
    localparam int Y_MAX     = 596;
    localparam int X_LAST    = 63;
    localparam int SCORE_MAX = 9999;
endpackage

// File: rtl/step_tick.sv
// step_tick: divider producing a one-cycle tick every DIV cycles, with sync clear
module step_tick #(
    parameter int DIV = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/ball_move_sched.sv
// ball_move_sched: game FSM, move arbitration and tick-paced strobes for the ball datapath
module ball_move_sched
    import ball_pkg::*;
#(
    parameter int STEP_DIV     = 250000,
    parameter int FREEZE_TICKS = 50,
    parameter int LIVES_INIT   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        kbd_left,
    input  logic        kbd_right,
    input  logic        hit,
    input  logic [8:0]  x_ball,
    input  logic [9:0]  y_ball,
    output logic        ball_rst,
    output logic        left,
    output logic        right,
    output logic [1:0]  state,
    output logic [2:0]  lives,
    output logic [13:0] score,
    output logic        at_edge
);
    localparam int FW = $clog2(FREEZE_TICKS + 1);
    state_t st;
    logic start_q, armed, tick, start_edge, go, use_kbd, src_l, src_r, wrap;
    logic [8:0] x_q;
    logic [FW-1:0] frz;
    // armed blocks a start held high through reset from counting as an edge
    assign start_edge = start & ~start_q & armed;
    assign go = start_edge & (st == ST_IDLE || st == ST_OVER);
    assign use_kbd = kbd_left | kbd_right;
    assign src_l = use_kbd ? kbd_left : btn_left;
    assign src_r = use_kbd ? kbd_right : btn_right;
    assign wrap = x_q == 9'(X_LAST) && x_ball == '0;
    assign state = st;
    assign at_edge = y_ball <= 10'(Y_MIN) || y_ball >= 10'(Y_MAX);
    step_tick #(.DIV(STEP_DIV)) u_tick (
        .clk  (clk),
        .rst  (reset),
        .clr  (go),
        .tick (tick)
    );
    always_ff @(posedge clk)
        if (reset) begin
            st <= ST_IDLE;
            lives <= 3'(LIVES_INIT);
            score <= '0;
            ball_rst <= 1'b0;
            left <= 1'b0;
            right <= 1'b0;
            frz <= '0;
            start_q <= 1'b0;
            armed <= 1'b0;
            x_q <= '0;
        end else begin
            start_q <= start;
            armed <= armed | ~start;
            x_q <= x_ball;
            ball_rst <= go;
            left <= st == ST_PLAY && tick && !hit && src_l && !src_r;
            right <= st == ST_PLAY && tick && !hit && src_r && !src_l;
            case (st)
                ST_IDLE, ST_OVER:
                    if (go) begin
                        st <= ST_PLAY;
                        lives <= 3'(LIVES_INIT);
                        score <= '0;
                    end
                ST_PLAY:
                    if (hit) begin
                        lives <= lives - 3'd1;
                        if (lives == 3'd1) st <= ST_OVER;
                        else begin
                            st <= ST_FREEZE;
                            frz <= FW'(FREEZE_TICKS);
                        end
                    end else if (wrap && score != 14'(SCORE_MAX)) score <= score + 14'd1;
                ST_FREEZE:
                    if (tick) begin
                        frz <= frz - 1'b1;
                        if (frz == FW'(1)) st <= ST_PLAY;
                    end
            endcase
        end
endmodule
